// File: rtl/iguana_pkg.sv
// Shared constants for the Iguana HyperBus init sequencer: the config-write
// table, the status register address and the sequencer state encoding.
package iguana_pkg;

  localparam logic [47:0] RegOutHyperBusBase = 48'h0000_0300_A000;

  localparam int unsigned HyperCfgNumWrites = 4;

  // Element [0] is written first.
  localparam logic [HyperCfgNumWrites-1:0][47:0] HyperCfgAddr = {
    RegOutHyperBusBase + 48'h00C,
    RegOutHyperBusBase + 48'h008,
    RegOutHyperBusBase + 48'h004,
    RegOutHyperBusBase + 48'h000
  };

  localparam logic [HyperCfgNumWrites-1:0][31:0] HyperCfgData = {
    32'h0000_0001,
    32'h0000_8F1F,
    32'h0000_0006,
    32'h0000_00E6
  };

  localparam logic [47:0] HyperStatusAddr = RegOutHyperBusBase + 48'h020;

  typedef enum logic [2:0] {
    HI_PWRUP   = 3'd0,
    HI_CFG_WR  = 3'd1,
    HI_POLL_RD = 3'd2,
    HI_DONE    = 3'd3,
    HI_FAIL    = 3'd4
  } hyper_init_state_e;

endpackage

// File: rtl/iguana_hyper_init_ctrl.sv
// HyperBus post-reset init sequencer and config-port arbiter.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   HI_PWRUP   | waiting out the HyperRAM power-up time (or bypass strap)
//   HI_CFG_WR  | writing the config table, one entry per accepted beat
//   HI_POLL_RD | reading the status register until bit 0 is set
//   HI_DONE    | init succeeded, Cheshire owns the config port
//   HI_FAIL    | init failed (bus error or poll timeout), Cheshire owns port
module iguana_hyper_init_ctrl
  import iguana_pkg::*;
#(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned PwrUpCycles  = 7500,
  parameter int unsigned NumCfgWrites = 4,
  parameter logic [NumCfgWrites-1:0][AddrWidth-1:0] CfgAddr    = HyperCfgAddr,
  parameter logic [NumCfgWrites-1:0][DataWidth-1:0] CfgData    = HyperCfgData,
  parameter logic [AddrWidth-1:0]                   StatusAddr = HyperStatusAddr,
  parameter int unsigned PollTimeout  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bypass_i,
  input  logic [AddrWidth-1:0]   slv_addr_i,
  input  logic                   slv_write_i,
  input  logic [DataWidth-1:0]   slv_wdata_i,
  input  logic [DataWidth/8-1:0] slv_wstrb_i,
  input  logic                   slv_valid_i,
  output logic [DataWidth-1:0]   slv_rdata_o,
  output logic                   slv_error_o,
  output logic                   slv_ready_o,
  output logic [AddrWidth-1:0]   mst_addr_o,
  output logic                   mst_write_o,
  output logic [DataWidth-1:0]   mst_wdata_o,
  output logic [DataWidth/8-1:0] mst_wstrb_o,
  output logic                   mst_valid_o,
  input  logic [DataWidth-1:0]   mst_rdata_i,
  input  logic                   mst_error_i,
  input  logic                   mst_ready_i,
  output logic                   boot_done_o,
  output logic                   boot_err_o
);

  localparam int PW = $clog2(PwrUpCycles + 1);
  localparam int TW = $clog2(PollTimeout + 1);
  localparam int IW = $clog2(NumCfgWrites + 1);
  localparam logic [PW-1:0] PwrLast  = PW'(PwrUpCycles - 1);
  localparam logic [TW-1:0] PollLast = TW'(PollTimeout - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NumCfgWrites - 1);

  hyper_init_state_e state_q, state_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [TW-1:0] poll_cnt_q, poll_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic done_q, done_d, err_q, err_d;
  logic poll_go;

  logic                   req_valid_q, req_valid_d;
  logic                   req_write_q, req_write_d;
  logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
  logic [DataWidth-1:0]   req_wdata_q, req_wdata_d;
  logic [DataWidth/8-1:0] req_wstrb_q, req_wstrb_d;
  logic                   terminal;

  function automatic logic [AddrWidth-1:0] cfg_addr_at(input logic [IW-1:0] i);
    cfg_addr_at = '0;
    for (int k = 0; k < int'(NumCfgWrites); k++)
      if (i == IW'(k)) cfg_addr_at = CfgAddr[k];
  endfunction

  function automatic logic [DataWidth-1:0] cfg_data_at(input logic [IW-1:0] i);
    cfg_data_at = '0;
    for (int k = 0; k < int'(NumCfgWrites); k++)
      if (i == IW'(k)) cfg_data_at = CfgData[k];
  endfunction

  // State, counters, status flags and the registered downstream request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HI_PWRUP;
      pwr_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

  // Next state, and the request to present in the next cycle.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    idx_d       = idx_q;
    done_d      = done_q;
    err_d       = err_q;
    poll_go     = 1'b1;
    req_valid_d = 1'b0;
    req_write_d = 1'b0;
    req_addr_d  = '0;
    req_wdata_d = '0;
    req_wstrb_d = '0;

    case (state_q)
      HI_PWRUP: begin
        pwr_cnt_d = pwr_cnt_q + 1'b1;
        if (bypass_i) begin
          state_d = HI_DONE;
          done_d  = 1'b1;
        end else if (pwr_cnt_q == PwrLast) begin
          state_d = HI_CFG_WR;
          idx_d   = '0;
        end
      end
      HI_CFG_WR: begin
        if (mst_ready_i) begin
          if (mst_error_i) begin
            state_d = HI_FAIL;
            err_d   = 1'b1;
          end else if (idx_q == IdxLast) begin
            state_d    = HI_POLL_RD;
            poll_cnt_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HI_POLL_RD: begin
        // An idle cycle (req_valid_q low) always re-issues the read.
        if (req_valid_q && mst_ready_i) begin
          if (mst_error_i) begin
            state_d = HI_FAIL;
            err_d   = 1'b1;
          end else if (mst_rdata_i[0]) begin
            state_d = HI_DONE;
            done_d  = 1'b1;
          end else if (poll_cnt_q == PollLast) begin
            state_d = HI_FAIL;
            err_d   = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            poll_go    = 1'b0;
          end
        end
      end
      HI_DONE, HI_FAIL: ;
      default: state_d = HI_PWRUP;
    endcase

    if (state_d == HI_CFG_WR) begin
      req_valid_d = 1'b1;
      req_write_d = 1'b1;
      req_addr_d  = cfg_addr_at(idx_d);
      req_wdata_d = cfg_data_at(idx_d);
      req_wstrb_d = '1;
    end else if (state_d == HI_POLL_RD) begin
      req_valid_d = poll_go;
      req_addr_d  = StatusAddr;
    end
  end

  assign terminal    = (state_q == HI_DONE) || (state_q == HI_FAIL);
  assign boot_done_o = done_q;
  assign boot_err_o  = err_q;

  // Port ownership: sequencer's registered request until terminal, then Cheshire.
  always_comb begin
    if (terminal) begin
      mst_addr_o  = slv_addr_i;
      mst_write_o = slv_write_i;
      mst_wdata_o = slv_wdata_i;
      mst_wstrb_o = slv_wstrb_i;
      mst_valid_o = slv_valid_i;
      slv_rdata_o = mst_rdata_i;
      slv_error_o = mst_error_i;
      slv_ready_o = mst_ready_i;
    end else begin
      mst_addr_o  = req_addr_q;
      mst_write_o = req_write_q;
      mst_wdata_o = req_wdata_q;
      mst_wstrb_o = req_wstrb_q;
      mst_valid_o = req_valid_q;
      slv_rdata_o = '0;
      slv_error_o = 1'b0;
      slv_ready_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_iguana_hyper_init_ctrl.sv
// Bench for the HyperBus init sequencer: a reactive downstream responder
// driven by a per-run scenario (error beat, number of not-ready polls,
// random ready latency) and a scenario-level model of the expected beats.
module tb_iguana_hyper_init_ctrl;

  localparam int AW  = 48;
  localparam int DW  = 32;
  localparam int NW  = 4;
  localparam int PWR = 8;
  localparam int PT  = 16;

  localparam logic [47:0] EXP_STATUS = 48'h0000_0300_A020;
  logic [47:0] exp_addr [NW];
  logic [31:0] exp_data [NW];

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          bypass_i = 1'b0;
  logic [AW-1:0] slv_addr_i = '0;
  logic          slv_write_i = 1'b0;
  logic [DW-1:0] slv_wdata_i = '0;
  logic [3:0]    slv_wstrb_i = '0;
  logic          slv_valid_i = 1'b0;
  logic [DW-1:0] slv_rdata_o;
  logic          slv_error_o, slv_ready_o;
  logic [AW-1:0] mst_addr_o;
  logic          mst_write_o;
  logic [DW-1:0] mst_wdata_o;
  logic [3:0]    mst_wstrb_o;
  logic          mst_valid_o;
  logic [DW-1:0] mst_rdata_i = '0;
  logic          mst_error_i = 1'b0;
  logic          mst_ready_i = 1'b0;
  logic          boot_done_o, boot_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  iguana_hyper_init_ctrl #(
    .PwrUpCycles(PWR),
    .PollTimeout(PT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bypass_i(bypass_i),
    .slv_addr_i(slv_addr_i), .slv_write_i(slv_write_i), .slv_wdata_i(slv_wdata_i),
    .slv_wstrb_i(slv_wstrb_i), .slv_valid_i(slv_valid_i),
    .slv_rdata_o(slv_rdata_o), .slv_error_o(slv_error_o), .slv_ready_o(slv_ready_o),
    .mst_addr_o(mst_addr_o), .mst_write_o(mst_write_o), .mst_wdata_o(mst_wdata_o),
    .mst_wstrb_o(mst_wstrb_o), .mst_valid_o(mst_valid_o),
    .mst_rdata_i(mst_rdata_i), .mst_error_i(mst_error_i), .mst_ready_i(mst_ready_i),
    .boot_done_o(boot_done_o), .boot_err_o(boot_err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive random traffic on both sides once Cheshire owns the port.
  task automatic check_passthrough(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] d, r;
    logic [3:0]    s;
    logic          w, v, rdy, e;
    for (int i = 0; i < n; i++) begin
      a = {16'($urandom), 32'($urandom)};
      d = $urandom; r = $urandom; s = 4'($urandom);
      w = 1'($urandom); v = 1'($urandom); rdy = 1'($urandom); e = 1'($urandom);
      slv_addr_i = a; slv_wdata_i = d; slv_wstrb_i = s; slv_write_i = w; slv_valid_i = v;
      mst_rdata_i = r; mst_ready_i = rdy; mst_error_i = e;
      #1;
      check_eq("pt_addr",  64'(mst_addr_o),  64'(a));
      check_eq("pt_wdata", 64'(mst_wdata_o), 64'(d));
      check_eq("pt_wstrb", 64'(mst_wstrb_o), 64'(s));
      check_eq("pt_write", 64'(mst_write_o), 64'(w));
      check_eq("pt_valid", 64'(mst_valid_o), 64'(v));
      check_eq("pt_ready", 64'(slv_ready_o), 64'(rdy));
      check_eq("pt_rdata", 64'(slv_rdata_o), 64'(r));
      check_eq("pt_error", 64'(slv_error_o), 64'(e));
      @(negedge clk_i);
    end
    slv_valid_i = 1'b0; mst_ready_i = 1'b0; mst_error_i = 1'b0;
    #1 check_eq("pt_idle_valid", 64'(mst_valid_o), 64'd0);
  endtask

  // err_beat: write beat that errors (-1 none); zeros: not-ready polls
  // before ready; rst_beat: beat at whose start rst_i is pulsed (-1 none).
  task automatic run_init(input int err_beat, input int zeros, input int rst_beat, input int max_wait);
    int  cyc, beat, total_beats, last_acc, wait_left, rd_i;
    bit  in_beat, finished, exp_done, exp_err, st;
    logic [AW-1:0] held_addr;
    logic          held_write;
    logic [DW-1:0] r;
    logic          e;

    if (err_beat >= 0) begin
      total_beats = err_beat + 1;
      exp_done = 1'b0; exp_err = 1'b1;
    end else begin
      total_beats = NW + ((zeros < PT) ? zeros + 1 : PT);
      exp_done = (zeros < PT); exp_err = !(zeros < PT);
    end

    rst_i = 1'b1; bypass_i = 1'b0;
    mst_ready_i = 1'b0; mst_error_i = 1'b0; mst_rdata_i = '0;
    held_addr = 48'h0000_0100_0000 + 48'($urandom_range(255, 0) * 4);
    held_write = 1'($urandom);
    slv_addr_i = held_addr; slv_write_i = held_write;
    slv_wdata_i = $urandom; slv_wstrb_i = 4'hF; slv_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("rst_valid", 64'(mst_valid_o), 64'd0);
    check_eq("rst_flags", 64'({boot_done_o, boot_err_o}), 64'd0);
    check_eq("rst_slv_ready", 64'(slv_ready_o), 64'd0);
    rst_i = 1'b0;

    cyc = 0; beat = 0; last_acc = -10; in_beat = 1'b0; finished = 1'b0;
    wait_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
    while (!finished && cyc < 600) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      mst_ready_i = 1'b0; mst_error_i = 1'b0; mst_rdata_i = '0;
      if (beat == total_beats) begin
        check_eq("boot_done", 64'(boot_done_o), 64'(exp_done));
        check_eq("boot_err",  64'(boot_err_o),  64'(exp_err));
        finished = 1'b1;
      end else begin
        check_eq("flags_early", 64'({boot_done_o, boot_err_o}), 64'd0);
        check_eq("slv_stall",   64'(slv_ready_o), 64'd0);
        if (in_beat)         check_eq("valid_held",  64'(mst_valid_o), 64'd1);
        else if (beat == 0)  check_eq("pwrup_valid", 64'(mst_valid_o), 64'(cyc >= PWR));
        else if (beat < NW)  check_eq("wr_b2b",      64'(mst_valid_o), 64'd1);
        else if (beat > NW)  check_eq("poll_gap",    64'(mst_valid_o), 64'(cyc != last_acc + 1));
        if (mst_valid_o) begin
          if (beat < NW) begin
            check_eq("wr_addr",  64'(mst_addr_o),  64'(exp_addr[beat]));
            check_eq("wr_data",  64'(mst_wdata_o), 64'(exp_data[beat]));
            check_eq("wr_write", 64'(mst_write_o), 64'd1);
            check_eq("wr_strb",  64'(mst_wstrb_o), 64'hF);
          end else begin
            check_eq("rd_addr",  64'(mst_addr_o),  64'(EXP_STATUS));
            check_eq("rd_write", 64'(mst_write_o), 64'd0);
            check_eq("rd_wdata", 64'(mst_wdata_o), 64'd0);
          end
          if (beat == rst_beat && !in_beat) begin
            #1 rst_i = 1'b1;
            #1 check_eq("rst_async_valid", 64'(mst_valid_o), 64'd0);
            return;
          end
          if (wait_left > 0) begin
            wait_left--;
            in_beat = 1'b1;
          end else begin
            mst_ready_i = 1'b1;
            if (beat < NW) begin
              mst_error_i = (beat == err_beat);
            end else begin
              rd_i = beat - NW;
              st = (rd_i >= zeros);
              mst_rdata_i = {31'($urandom), st};
            end
            beat++;
            last_acc = cyc;
            in_beat = 1'b0;
            wait_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
          end
        end
      end
    end
    check_eq("beats_seen", 64'(beat), 64'(total_beats));

    if (finished) begin
      // The request Cheshire held throughout init now reaches the port.
      check_eq("held_valid", 64'(mst_valid_o), 64'd1);
      check_eq("held_addr",  64'(mst_addr_o),  64'(held_addr));
      check_eq("held_write", 64'(mst_write_o), 64'(held_write));
      r = $urandom; e = 1'($urandom);
      mst_rdata_i = r; mst_error_i = e; mst_ready_i = 1'b1;
      #1;
      check_eq("held_ready", 64'(slv_ready_o), 64'd1);
      check_eq("held_rdata", 64'(slv_rdata_o), 64'(r));
      check_eq("held_error", 64'(slv_error_o), 64'(e));
      @(negedge clk_i);
      check_passthrough(3);
      check_eq("final_done", 64'(boot_done_o), 64'(exp_done));
      check_eq("final_err",  64'(boot_err_o),  64'(exp_err));
    end
  endtask

  task automatic run_bypass();
    rst_i = 1'b1; bypass_i = 1'b1; slv_valid_i = 1'b0;
    mst_ready_i = 1'b0; mst_error_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("byp_done",   64'(boot_done_o), 64'd1);
    check_eq("byp_err",    64'(boot_err_o),  64'd0);
    check_eq("byp_no_mst", 64'(mst_valid_o), 64'd0);
    slv_addr_i = 48'h1_0000_0010; slv_wdata_i = 32'hDEADBEEF;
    slv_write_i = 1'b1; slv_wstrb_i = 4'hF; slv_valid_i = 1'b1; mst_ready_i = 1'b1;
    #1;
    check_eq("byp_addr",  64'(mst_addr_o),  64'h1_0000_0010);
    check_eq("byp_wdata", 64'(mst_wdata_o), 64'hDEADBEEF);
    check_eq("byp_write", 64'(mst_write_o), 64'd1);
    check_eq("byp_valid", 64'(mst_valid_o), 64'd1);
    check_eq("byp_ready", 64'(slv_ready_o), 64'd1);
    @(negedge clk_i);
    slv_valid_i = 1'b0; mst_ready_i = 1'b0; bypass_i = 1'b0;
  endtask

  initial begin
    int eb, z;
    exp_addr = '{48'h0000_0300_A000, 48'h0000_0300_A004, 48'h0000_0300_A008, 48'h0000_0300_A00C};
    exp_data = '{32'h0000_00E6, 32'h0000_0006, 32'h0000_8F1F, 32'h0000_0001};

    run_init(-1, 2, -1, 0);
    run_init(1, 0, -1, 0);
    run_init(-1, PT + 5, -1, 0);
    run_init(-1, 0, 2, 0);
    run_init(-1, 0, -1, 0);
    run_init(-1, PT - 1, -1, 1);
    run_bypass();
    for (int t = 0; t < 12; t++) begin
      eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NW - 1, 0)) : -1;
      z  = int'($urandom_range(20, 0));
      run_init(eb, z, -1, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iguana_hyper_init_ctrl.md
Name: iguana_hyper_init_ctrl

Overview:
Post-reset initialization sequencer for the single-PHY, single-chip HyperBus memory behind the Cheshire register-bus output. After reset it waits out the HyperRAM power-up time, writes a fixed table of configuration words into the HyperBus controller's config registers, and polls a status register until the device reports ready. It then asserts boot_done_o, which gates core fetch from boot address 0x0100_0000. It also arbitrates the HyperBus config register-bus port: the sequencer owns the port during init, and Cheshire's external reg slave port 0 owns it afterwards.

Parameters:
AddrWidth, 48, register-bus address width
DataWidth, 32, register-bus data width
PwrUpCycles, 7500, clk_i cycles to wait after reset before the first access (150 us at 50 MHz); must be >= 1
NumCfgWrites, 4, number of config-table entries; 1..8
CfgAddr, iguana_pkg::HyperCfgAddr, array[NumCfgWrites] of absolute write addresses
CfgData, iguana_pkg::HyperCfgData, array[NumCfgWrites] of write data
StatusAddr, iguana_pkg::HyperStatusAddr, address of the ready-status register (bit 0 = ready)
PollTimeout, 1024, maximum number of status reads before failure

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
bypass_i  in  1  boot strap, sampled at every cycle in PWRUP; when 1, the block skips init
slv_addr_i / slv_write_i / slv_wdata_i / slv_wstrb_i / slv_valid_i  in  AddrWidth/1/DataWidth/DataWidth/8/1  request from Cheshire reg out port 0
slv_rdata_o / slv_error_o / slv_ready_o  out  DataWidth/1/1  response to Cheshire
mst_addr_o / mst_write_o / mst_wdata_o / mst_wstrb_o / mst_valid_o  out  AddrWidth/1/DataWidth/DataWidth/8/1  request to the HyperBus config port
mst_rdata_i / mst_error_i / mst_ready_i  in  DataWidth/1/1  response from the HyperBus config port
boot_done_o  out  1  init finished (success or bypass)
boot_err_o  out  1  init failed (bus error or timeout)

Behaviour:
- Register-bus handshake:
  - A request is held stable while valid=1 until ready=1.
  - The response (rdata, error) is valid in the same cycle as ready.
  - The master never drops valid before ready.
- States: PWRUP, CFG_WR, POLL_RD, DONE, FAIL. Reset state is PWRUP.
- Reset values: all counters = 0, mst_valid_o = 0, slv_ready_o = 0, boot_done_o = 0, boot_err_o = 0.
- PWRUP:
  - Counter increments each cycle.
  - If bypass_i=1, go to DONE next cycle.
  - When the counter reaches PwrUpCycles-1, go to CFG_WR with index = 0.
- CFG_WR:
  - Drive mst_addr_o = CfgAddr[idx], mst_write_o = 1, mst_wdata_o = CfgData[idx], mst_wstrb_o = all ones, mst_valid_o = 1.
  - On mst_ready_i with mst_error_i=1, go to FAIL.
  - On mst_ready_i with mst_error_i=0, increment idx. If idx was NumCfgWrites-1, go to POLL_RD with the poll counter cleared.
  - mst_valid_o stays high back-to-back across table entries; there are no idle cycles between entries.
- POLL_RD:
  - Drive a read of StatusAddr with mst_wdata_o = 0.
  - On ready with error, go to FAIL.
  - On ready with rdata[0]=1, go to DONE.
  - On ready with rdata[0]=0, increment the poll counter. When the counter reaches PollTimeout-1 with no ready status, go to FAIL.
  - Exactly one idle cycle (mst_valid_o=0) separates consecutive polls.
- DONE and FAIL:
  - Both are terminal until reset.
  - mst_* = slv_* and slv_* = mst_* (combinational pass-through, zero latency).
  - boot_done_o = 1 in DONE; boot_err_o = 1 in FAIL. Both are registered and asserted in the first cycle of the state.
- Non-terminal states: slv_ready_o = 0, slv_rdata_o = 0, slv_error_o = 0. Cheshire requests stall and are not dropped.
- Outputs from non-terminal states are registered; no combinational path from slv_* to mst_* before DONE/FAIL.
- Reset mid-transaction: asserting rst_i returns to PWRUP immediately, with mst_valid_o = 0 asynchronously. The downstream controller's in-flight request is abandoned; the downstream is reset by the same rst_i.
- Counter widths: PWRUP counter $clog2(PwrUpCycles+1); poll counter $clog2(PollTimeout+1); idx $clog2(NumCfgWrites+1). No wrap-around is possible.

Decomposition:
- iguana_pkg: HyperCfgNumWrites, HyperCfgAddr/HyperCfgData arrays (derived from RegOutHyperBusBase), HyperStatusAddr, and the enum hyper_init_state_e.
- No sub-module. The pass-through mux and FSM live in one file.
- reg_req_t/reg_rsp_t struct ports are mapped at the iguana_soc instantiation.

Test Plan:
- Reset with PwrUpCycles=8 and bypass_i=0, mst_ready_i tied to 1 -> first mst_valid_o at cycle 8 after reset deassertion, 4 consecutive write beats matching the table, then a status read.
- Status returns 0 twice then 1 -> 3 reads, each separated by one idle cycle; boot_done_o rises the cycle after the third ready; boot_err_o stays 0.
- mst_error_i=1 on the 2nd config write -> FAIL, boot_err_o=1, no further config writes; a subsequent slv_valid_i read is passed through.
- Status stuck at 0 with PollTimeout=16 -> exactly 16 reads, then boot_err_o=1 and boot_done_o=0.
- bypass_i=1 at reset release -> boot_done_o=1 on cycle 1, zero mst accesses; a Cheshire write to 0x1_0000_0010 with data 0xDEADBEEF appears on mst_* in the same cycle.
- slv_valid_i held during CFG_WR -> slv_ready_o=0 until DONE, then the request completes. rst_i pulsed mid-CFG_WR -> mst_valid_o=0 immediately and the sequence restarts from PWRUP.
